store_buffer: RTL

- Posted-write FIFO between the pipelined core's Memory stage and the data memory port.
- Accepts stores (address, data, byte-access code) from the M stage, so stores retire without waiting on the memory port.
- Drains one store per cycle into dmemory whenever the port is not needed by a load.
- Stalls the core when the buffer is full, or when a load's word address matches any pending store (RAW hazard), until the conflicting entries have drained.

---
 rtl/sb_pkg.sv | 20 ++
 rtl/sb_match.sv | 22 ++
 rtl/store_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer between the M stage and dmemory.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } byte_access_t;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    byte_access_t     bacc;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Word-granular load/store address comparator: flags a RAW hazard when a load
// targets the same 32-bit word as any valid pending store.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic            rd,
  input  logic [AW-3:0]   ld_word,
  input  logic [AW-3:0]   st_word [DEPTH],
  input  logic [DEPTH-1:0] valid,
  output logic            hazard
);

  // OR-reduce the per-entry matches; sub-word overlap is not resolved on purpose
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd && valid[i] && (st_word[i] == ld_word)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO: retires M-stage stores immediately and drains them into
// dmemory one per cycle whenever the port is not claimed by a load.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWriteM,
  input  logic                     MemReadM,
  input  logic [AW-1:0]            ALUResultM,
  input  logic [DW-1:0]            WriteDataM,
  input  logic [1:0]               ByteAccessM,
  output logic                     StallM,
  output logic                     MemWriteD,
  output logic [AW-1:0]            AddrD,
  output logic [DW-1:0]            WriteDataD,
  output logic [1:0]               ByteAccessD,
  output logic                     SbEmpty,
  output logic [$clog2(DEPTH):0]   SbCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  byte_access_t     bacc_q [DEPTH];
  logic [AW-3:0]    word_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic full;
  logic empty;
  logic ld_only;
  logic hazard;
  logic enq;
  logic drain;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A store in the same cycle as a load wins; the load is not hazard-checked
  assign ld_only = MemReadM && !MemWriteM;

  // Word addresses of all entries for the hazard comparator
  always_comb begin
    for (int i = 0; i < DEPTH; i++) word_q[i] = addr_q[i][AW-1:2];
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .rd      (ld_only),
    .ld_word (ALUResultM[AW-1:2]),
    .st_word (word_q),
    .valid   (valid_q),
    .hazard  (hazard)
  );

  assign enq    = MemWriteM && !full;
  assign drain  = !empty && (!MemReadM || hazard);
  assign StallM = (MemWriteM && full) || hazard;

  assign MemWriteD   = drain;
  assign AddrD       = drain ? addr_q[head_q] : ALUResultM;
  assign WriteDataD  = drain ? data_q[head_q] : '0;
  assign ByteAccessD = drain ? bacc_q[head_q] : ByteAccessM;
  assign SbEmpty     = empty;
  assign SbCount     = count_q;

  // Pointer, occupancy and valid bookkeeping; reset discards pending stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload capture; contents are qualified by valid so need no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= ALUResultM;
      data_q[tail_q] <= WriteDataM;
      bacc_q[tail_q] <= byte_access_t'(ByteAccessM);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CW'(DEPTH));
  a_count_matches_valid : assert property (@(posedge clk) disable iff (!reset)
    int'(count_q) == $countones(valid_q));

endmodule
